// File: rtl/vip_stream_splitter.sv
`default_nettype none
// ============================================================================
//  Module   : vip_stream_splitter (plus helper vip_stream_splitter_fifo)
//  Purpose  : Broadcasts every accepted Avalon-ST VIP beat from one sink to
//             two sources (A and B). Each source has its own 2-entry buffer
//             and its own backpressure. Tracks packet framing, drops beats
//             that arrive outside a packet, and can limit B to video packets.
//  Ports    : clk, reset                  - clock, sync active-high reset
//             asi_din_*                   - sink (ready/valid/sop/eop/data)
//             aso_doutA_*, aso_doutB_*    - the two sources
//             drop_pulse                  - one pulse per discarded beat
//             sop_err_pulse               - one pulse per SOP inside a packet
//             frame_count                 - completed video packets (wraps)
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  vip_stream_splitter_fifo: 2-deep FIFO with registered count. The head
//  entry comes straight from the storage registers, and the output is forced
//  to zero while the FIFO is empty.
// ----------------------------------------------------------------------------
module vip_stream_splitter_fifo #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr] <= din;
                r_wr        <= ~r_wr;
            end
            if (pop) begin
                r_rd <= ~r_rd;
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({push, pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign valid = (r_cnt != 2'd0);
    assign dout  = valid ? r_mem[r_rd] : '0;
    assign count = r_cnt;

endmodule

module vip_stream_splitter #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int B_VIDEO_ONLY     = 0
) (
    input  logic                                        clk,
    input  logic                                        reset,

    output logic                                        asi_din_ready,
    input  logic                                        asi_din_valid,
    input  logic                                        asi_din_startofpacket,
    input  logic                                        asi_din_endofpacket,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] asi_din_data,

    input  logic                                        aso_doutA_ready,
    output logic                                        aso_doutA_valid,
    output logic                                        aso_doutA_startofpacket,
    output logic                                        aso_doutA_endofpacket,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] aso_doutA_data,

    input  logic                                        aso_doutB_ready,
    output logic                                        aso_doutB_valid,
    output logic                                        aso_doutB_startofpacket,
    output logic                                        aso_doutB_endofpacket,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] aso_doutB_data,

    output logic                                        drop_pulse,
    output logic                                        sop_err_pulse,
    output logic [15:0]                                 frame_count
);

    localparam int c_dw = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int c_fw = c_dw + 2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_PACKET = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_type;
    logic [3:0]  w_type_nxt;
    logic        r_fwd_b;
    logic        w_fwd_b_nxt;
    logic        r_rst;
    logic        r_drop;
    logic        r_sop_err;
    logic [15:0] r_frame_count;

    logic        w_accept;
    logic        w_push_a;
    logic        w_push_b;
    logic        w_drop;
    logic        w_sop_err;
    logic        w_count_frame;
    logic [3:0]  w_sop_type;
    logic        w_sop_fwd_b;

    logic [c_fw-1:0] w_din_beat;
    logic [c_fw-1:0] w_dout_a;
    logic [c_fw-1:0] w_dout_b;
    logic [1:0]      w_cnt_a;
    logic [1:0]      w_cnt_b;
    logic            w_pop_a;
    logic            w_pop_b;

    // Ready depends only on registered state, so downstream ready never
    // reaches upstream ready combinationally. Space is needed in both
    // buffers even when the beat will not be pushed to B.
    assign asi_din_ready = !r_rst && (w_cnt_a != 2'd2) && (w_cnt_b != 2'd2);
    assign w_accept      = asi_din_valid && asi_din_ready;

    assign w_sop_type  = asi_din_data[3:0];
    assign w_sop_fwd_b = !((B_VIDEO_ONLY != 0) && (w_sop_type != 4'd0));
    assign w_din_beat  = {asi_din_startofpacket, asi_din_endofpacket, asi_din_data};

    always_comb begin
        w_state_nxt   = r_state;
        w_type_nxt    = r_type;
        w_fwd_b_nxt   = r_fwd_b;
        w_push_a      = 1'b0;
        w_push_b      = 1'b0;
        w_drop        = 1'b0;
        w_sop_err     = 1'b0;
        w_count_frame = 1'b0;
        if (w_accept) begin
            if (asi_din_startofpacket) begin
                // A SOP always starts a packet; inside a packet it aborts
                // the previous one, which stays unterminated downstream.
                w_push_a    = 1'b1;
                w_push_b    = w_sop_fwd_b;
                w_type_nxt  = w_sop_type;
                w_fwd_b_nxt = w_sop_fwd_b;
                w_sop_err   = (r_state == ST_PACKET);
                if (asi_din_endofpacket) begin
                    w_state_nxt   = ST_IDLE;
                    w_count_frame = (w_sop_type == 4'd0);
                end else begin
                    w_state_nxt = ST_PACKET;
                end
            end else if (r_state == ST_PACKET) begin
                w_push_a = 1'b1;
                w_push_b = r_fwd_b;
                if (asi_din_endofpacket) begin
                    w_state_nxt   = ST_IDLE;
                    w_count_frame = (r_type == 4'd0);
                end
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // High in every reset cycle and in the first cycle after it.
        r_rst <= reset;
        if (reset) begin
            r_state       <= ST_IDLE;
            r_type        <= 4'd0;
            r_fwd_b       <= 1'b0;
            r_drop        <= 1'b0;
            r_sop_err     <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_type    <= w_type_nxt;
            r_fwd_b   <= w_fwd_b_nxt;
            r_drop    <= w_drop;
            r_sop_err <= w_sop_err;
            if (w_count_frame) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign w_pop_a = aso_doutA_valid && aso_doutA_ready;
    assign w_pop_b = aso_doutB_valid && aso_doutB_ready;

    vip_stream_splitter_fifo #(.WIDTH(c_fw)) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .push  (w_push_a),
        .din   (w_din_beat),
        .pop   (w_pop_a),
        .valid (aso_doutA_valid),
        .dout  (w_dout_a),
        .count (w_cnt_a)
    );

    vip_stream_splitter_fifo #(.WIDTH(c_fw)) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .push  (w_push_b),
        .din   (w_din_beat),
        .pop   (w_pop_b),
        .valid (aso_doutB_valid),
        .dout  (w_dout_b),
        .count (w_cnt_b)
    );

    assign aso_doutA_startofpacket = w_dout_a[c_fw-1];
    assign aso_doutA_endofpacket   = w_dout_a[c_fw-2];
    assign aso_doutA_data          = w_dout_a[c_dw-1:0];
    assign aso_doutB_startofpacket = w_dout_b[c_fw-1];
    assign aso_doutB_endofpacket   = w_dout_b[c_fw-2];
    assign aso_doutB_data          = w_dout_b[c_dw-1:0];

    assign drop_pulse    = r_drop;
    assign sop_err_pulse = r_sop_err;
    assign frame_count   = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vip_stream_splitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vip_stream_splitter
//  Purpose  : Self-checking bench for vip_stream_splitter. A cycle table
//             covers the basic packet, dropped beats and SOP-in-packet;
//             hand-written sequences cover backpressure, B video-only
//             filtering and reset in the middle of a packet.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vip_stream_splitter;

    localparam int DW = 24;
    typedef logic [DW+1:0] beat_t;
    typedef beat_t beat_q_t[$];

    typedef struct packed {
        logic          v;
        logic          s;
        logic          e;
        logic [DW-1:0] d;
        logic [72:0]   exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic [DW-1:0] din_data = '0;
    logic          rdy_a = 1'b1, rdy_b = 1'b1;

    logic          din_ready, a_valid, a_sop, a_eop, b_valid, b_sop, b_eop, drop, serr;
    logic [DW-1:0] a_data, b_data;
    logic [15:0]   fc;

    logic          v_din_ready, va_valid, va_sop, va_eop, vb_valid, vb_sop, vb_eop, v_drop, v_serr;
    logic [DW-1:0] va_data, vb_data;
    logic [15:0]   v_fc;

    vip_stream_splitter #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .B_VIDEO_ONLY(0)) dut (
        .clk(clk), .reset(reset),
        .asi_din_ready(din_ready), .asi_din_valid(din_valid),
        .asi_din_startofpacket(din_sop), .asi_din_endofpacket(din_eop), .asi_din_data(din_data),
        .aso_doutA_ready(rdy_a), .aso_doutA_valid(a_valid),
        .aso_doutA_startofpacket(a_sop), .aso_doutA_endofpacket(a_eop), .aso_doutA_data(a_data),
        .aso_doutB_ready(rdy_b), .aso_doutB_valid(b_valid),
        .aso_doutB_startofpacket(b_sop), .aso_doutB_endofpacket(b_eop), .aso_doutB_data(b_data),
        .drop_pulse(drop), .sop_err_pulse(serr), .frame_count(fc)
    );

    vip_stream_splitter #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .B_VIDEO_ONLY(1)) dut_v (
        .clk(clk), .reset(reset),
        .asi_din_ready(v_din_ready), .asi_din_valid(din_valid),
        .asi_din_startofpacket(din_sop), .asi_din_endofpacket(din_eop), .asi_din_data(din_data),
        .aso_doutA_ready(rdy_a), .aso_doutA_valid(va_valid),
        .aso_doutA_startofpacket(va_sop), .aso_doutA_endofpacket(va_eop), .aso_doutA_data(va_data),
        .aso_doutB_ready(rdy_b), .aso_doutB_valid(vb_valid),
        .aso_doutB_startofpacket(vb_sop), .aso_doutB_endofpacket(vb_eop), .aso_doutB_data(vb_data),
        .drop_pulse(v_drop), .sop_err_pulse(v_serr), .frame_count(v_fc)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, exp);
    endtask

    task automatic check_q(input string nm, input beat_q_t got, input beat_q_t exp);
        int bad;
        bad = -1;
        n_chk++;
        if (got.size() != exp.size()) bad = 0;
        else for (int i = 0; i < exp.size(); i++) if (bad < 0 && got[i] !== exp[i]) bad = i;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: got %0d beats required %0d beats, first difference at beat %0d",
                      nm, got.size(), exp.size(), bad);
    endtask

    function automatic beat_t bt(input logic s, input logic e, input logic [DW-1:0] d);
        return {s, e, d};
    endfunction

    // Same expected beat on A and B (B_VIDEO_ONLY=0 instance, readies high).
    function automatic vec_t mk(input logic v, input logic s, input logic e, input logic [DW-1:0] d,
                                input logic erdy, input logic ev, input logic es, input logic ee,
                                input logic [DW-1:0] ed, input logic edrop, input logic eserr,
                                input logic [15:0] efc);
        vec_t r;
        r.v = v; r.s = s; r.e = e; r.d = d;
        r.exp = {erdy, ev, es, ee, ed, ev, es, ee, ed, edrop, eserr, efc};
        return r;
    endfunction

    function automatic logic [72:0] out_vec();
        return {din_ready, a_valid, a_sop, a_eop, a_data, b_valid, b_sop, b_eop, b_data, drop, serr, fc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic s, input logic e, input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        din_valid = 1'b1; din_sop = s; din_eop = e; din_data = d;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (din_ready) got = 1'b1;
        end
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            n_chk++;
            $display("FAIL send_timeout: asi_din_ready stayed %b, required 1", din_ready);
        end
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    // Output monitor: records every beat that transfers on the next edge.
    bit      mon_en = 1'b0;
    beat_q_t qa, qb, qva, qvb;
    int      pops_a, pops_b, max_ahead;
    bit      saw_ready_low, b_held_ok;
    beat_t   b_held;

    always @(negedge clk) begin
        if (mon_en) begin
            if (a_valid && rdy_a) begin qa.push_back({a_sop, a_eop, a_data}); pops_a++; end
            if (b_valid && rdy_b) begin qb.push_back({b_sop, b_eop, b_data}); pops_b++; end
            if (va_valid && rdy_a) qva.push_back({va_sop, va_eop, va_data});
            if (vb_valid && rdy_b) qvb.push_back({vb_sop, vb_eop, vb_data});
            if (pops_a - pops_b > max_ahead) max_ahead = pops_a - pops_b;
            if (!din_ready) saw_ready_low = 1'b1;
            if (b_valid && !rdy_b) begin
                if (b_held_ok) check("b_head_stable", 128'({b_sop, b_eop, b_data}), 128'(b_held));
                b_held    = {b_sop, b_eop, b_data};
                b_held_ok = 1'b1;
            end else begin
                b_held_ok = 1'b0;
            end
        end
    end

    task automatic mon_start();
        qa.delete(); qb.delete(); qva.delete(); qvb.delete();
        pops_a = 0; pops_b = 0; max_ahead = 0;
        saw_ready_low = 1'b0; b_held_ok = 1'b0;
        mon_en = 1'b1;
    endtask

    vec_t    vecs[14];
    beat_q_t exp_q;

    initial begin
        vecs[0]  = mk(0, 0, 0, 24'h000000, 0, 0, 0, 0, 24'h000000, 0, 0, 16'd0);
        vecs[1]  = mk(1, 1, 0, 24'h000000, 1, 0, 0, 0, 24'h000000, 0, 0, 16'd0);
        vecs[2]  = mk(1, 0, 0, 24'h112233, 1, 1, 1, 0, 24'h000000, 0, 0, 16'd0);
        vecs[3]  = mk(1, 0, 0, 24'h445566, 1, 1, 0, 0, 24'h112233, 0, 0, 16'd0);
        vecs[4]  = mk(1, 0, 1, 24'h778899, 1, 1, 0, 0, 24'h445566, 0, 0, 16'd0);
        vecs[5]  = mk(1, 0, 0, 24'hAAAAAA, 1, 1, 0, 1, 24'h778899, 0, 0, 16'd1);
        vecs[6]  = mk(1, 0, 0, 24'hBBBBBB, 1, 0, 0, 0, 24'h000000, 1, 0, 16'd1);
        vecs[7]  = mk(0, 0, 0, 24'h000000, 1, 0, 0, 0, 24'h000000, 1, 0, 16'd1);
        vecs[8]  = mk(1, 1, 0, 24'h000000, 1, 0, 0, 0, 24'h000000, 0, 0, 16'd1);
        vecs[9]  = mk(1, 0, 0, 24'h010203, 1, 1, 1, 0, 24'h000000, 0, 0, 16'd1);
        vecs[10] = mk(1, 1, 0, 24'h000000, 1, 1, 0, 0, 24'h010203, 0, 0, 16'd1);
        vecs[11] = mk(1, 0, 1, 24'h040506, 1, 1, 1, 0, 24'h000000, 0, 1, 16'd1);
        vecs[12] = mk(0, 0, 0, 24'h000000, 1, 1, 0, 1, 24'h040506, 0, 0, 16'd2);
        vecs[13] = mk(0, 0, 0, 24'h000000, 1, 0, 0, 0, 24'h000000, 0, 0, 16'd2);

        // Reset values, then the cycle table starting in the post-reset cycle.
        reset = 1'b1;
        tick();
        tick();
        check("reset_values", 128'(out_vec()), 128'(0));
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            din_valid = vecs[i].v; din_sop = vecs[i].s; din_eop = vecs[i].e; din_data = vecs[i].d;
            #2;
            check($sformatf("table_row%0d", i), 128'(out_vec()), 128'(vecs[i].exp));
            tick();
        end
        din_valid = 1'b0;

        // B stalled for 5 cycles mid-packet.
        do_reset();
        tick();
        mon_start();
        fork
            begin
                send(1, 0, 24'h000000);
                send(0, 0, 24'h112233);
                send(0, 0, 24'h445566);
                send(0, 1, 24'h778899);
            end
            begin
                repeat (2) @(posedge clk);
                #1 rdy_b = 1'b0;
                repeat (5) @(posedge clk);
                #1 rdy_b = 1'b1;
            end
        join
        repeat (6) tick();
        mon_en = 1'b0;
        exp_q = {bt(1, 0, 24'h000000), bt(0, 0, 24'h112233), bt(0, 0, 24'h445566), bt(0, 1, 24'h778899)};
        check_q("bp_beats_a", qa, exp_q);
        check_q("bp_beats_b", qb, exp_q);
        check("bp_ready_dropped", 128'(saw_ready_low), 128'(1));
        check("bp_a_ahead_le2", 128'(max_ahead <= 2), 128'(1));
        check("bp_frame_count", 128'(fc), 128'(1));

        // B restricted to video: control packet then video packet.
        do_reset();
        tick();
        mon_start();
        send(1, 0, 24'h00000F);
        send(0, 0, 24'h111111);
        send(0, 1, 24'h222222);
        send(1, 0, 24'h000000);
        send(0, 1, 24'h333333);
        repeat (4) tick();
        mon_en = 1'b0;
        exp_q = {bt(1, 0, 24'h00000F), bt(0, 0, 24'h111111), bt(0, 1, 24'h222222),
                 bt(1, 0, 24'h000000), bt(0, 1, 24'h333333)};
        check_q("vo_beats_a", qva, exp_q);
        check_q("vo_beats_b_all", qb, exp_q);
        exp_q = {bt(1, 0, 24'h000000), bt(0, 1, 24'h333333)};
        check_q("vo_beats_b_video", qvb, exp_q);
        check("vo_frame_count", 128'(v_fc), 128'(1));
        check("vo_flags_idle", 128'({v_drop, v_serr, v_din_ready}), 128'(3'b001));

        // Reset while both buffers hold two beats.
        do_reset();
        tick();
        send(1, 0, 24'h000000);
        send(0, 1, 24'h0000AA);
        repeat (3) tick();
        rdy_a = 1'b0; rdy_b = 1'b0;
        send(1, 0, 24'h000000);
        send(0, 0, 24'h111111);
        check("rst_setup_full", 128'({din_ready, a_valid, b_valid, fc}), 128'({3'b011, 16'd1}));
        reset = 1'b1;
        tick();
        check("rst_cleared", 128'({din_ready, a_valid, b_valid, a_data, b_data, fc}), 128'(0));
        reset = 1'b0;
        #2;
        check("rst_ready_held_low", 128'(din_ready), 128'(0));
        tick();
        check("rst_ready_back", 128'({din_ready, a_valid, b_valid}), 128'(3'b100));
        rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (3) tick();
        check("rst_no_stale_output", 128'({a_valid, b_valid, fc}), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
